// File: rtl/control_pkg.sv
// ============================================================================
// control_pkg : shared types and encodings for the multicycle RV32I control
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_R = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate format needed while in DECODE: loads/stores fix their own
  // format, everything else precomputes the branch target.
  function automatic logic [2:0] decode_imm_type(input logic [6:0] op);
    case (op)
      OP_LOAD:  decode_imm_type = IMM_I;
      OP_STORE: decode_imm_type = IMM_S;
      default:  decode_imm_type = IMM_B;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/contador_instret.sv
// ============================================================================
// contador_instret : retired-instruction counter, wraps modulo 2^CNT_W
// Revision         : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module contador_instret #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/control_multiciclo.sv
// ============================================================================
// control_multiciclo : main control FSM of the multicycle RV32I core
// Revision           : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module control_multiciclo
  import control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic [2:0]       imm_type,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t state, state_next;
  logic   pending, pending_next;
  logic   fetch_req;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      pending <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    state_next   = state;
    pending_next = pending;
    fetch_req    = 1'b0;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    adr_src      = 1'b0;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    alu_op       = ALUOP_ADD;
    result_src   = RES_ALUOUT;
    imm_type     = IMM_I;
    illegal      = 1'b0;

    case (state)
      S_FETCH: begin
        // Once a fetch is requested it stays requested until the memory
        // answers, even if run is withdrawn meanwhile.
        fetch_req = run | pending;
        mem_req   = fetch_req;
        if (fetch_req) begin
          if (mem_ready) begin
            ir_write     = 1'b1;
            pc_write     = 1'b1;
            alu_src_b    = SRCB_FOUR;
            result_src   = RES_ALURESULT;
            pending_next = 1'b0;
            state_next   = S_DECODE;
          end else begin
            pending_next = 1'b1;
          end
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_type  = decode_imm_type(opcode);
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        imm_type   = IMM_I;
        state_next = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        imm_type   = IMM_J;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = zero;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        illegal    = 1'b1;
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase

    // The state register is already in FETCH during reset, but run would
    // still raise a request there; keep the memory port and strobes quiet.
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  contador_instret #(
    .CNT_W (CNT_W)
  ) u_instret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .count (instret)
  );

endmodule

`default_nettype wire

// File: doc/control_multiciclo.md
# control_multiciclo

Main control FSM for the multicycle RV32I core. It sequences the shared datapath: PC, instruction register, unified memory port, register bank, immediate generator and ALU, across FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps. It drives the immediate-type code consumed by the operand/immediate preparation logic, handles a wait-state memory handshake, counts retired instructions and traps illegal opcodes.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  permits starting a new instruction fetch.
- `opcode`  in  7  `IR[6:0]`, valid from DECODE onward.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the pending access this cycle.
- `mem_req`  out  1  memory access request.
- `mem_write`  out  1  the request is a store.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `pc_write`  out  1  PC load strobe.
- `ir_write`  out  1  IR and oldPC load strobe.
- `reg_write`  out  1  register bank write strobe.
- `alu_src_a`  out  2  00 PC, 01 oldPC, 10 rs1.
- `alu_src_b`  out  2  00 rs2, 01 imm, 10 constant 4.
- `alu_op`  out  2  00 add, 01 sub, 10 funct-decoded.
- `result_src`  out  2  00 ALUOut, 01 memory data, 10 ALU result.
- `imm_type`  out  3  000 I, 001 S, 010 R, 011 B, 100 J.
- `illegal`  out  1  sticky illegal-opcode trap.
- `instret`  out  CNT_W  retired-instruction count.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- FETCH:
  - Once `run` is 1, raise `mem_req` (`adr_src`=0). Hold `mem_req` until `mem_ready`, even if `run` drops. An internal pending flag enforces this.
  - On the `mem_ready` cycle: `ir_write`=1, `pc_write`=1, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10. Go to DECODE.
  - Without `mem_ready`, stay in FETCH.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `imm_type`=011 (precompute branch target). Dispatch on `opcode`:
  - 0000011 → MEMADR, `imm_type` I.
  - 0100011 → MEMADR, `imm_type` S.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BEQ.
  - 1101111 → JAL.
  - Anything else → TRAP.
- MEMADR: rs1+imm (`alu_src_a`=10, `alu_src_b`=01, add). Go to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: `mem_req`=1, `adr_src`=1. Wait for `mem_ready`, then go to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1. Go to FETCH.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1. Wait for `mem_ready`, then go to FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Go to ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10, `imm_type`=000. Go to ALUWB.
- JAL: `alu_src_a`=01, `alu_src_b`=10, `result_src`=00, `pc_write`=1, `imm_type`=100. Go to ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1. Go to FETCH.
- BEQ: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00. `pc_write`=`zero`; this is the only Mealy output. Go to FETCH.
- TRAP: `illegal`=1. All strobes and `mem_req` are 0. The FSM stays in TRAP until reset.
- `instret` increments by 1 on the final cycle of every legal instruction: MEMWB, the MEMWRITE handshake cycle, ALUWB, BEQ. It wraps modulo 2^CNT_W.
- Outputs not listed for a state are 0 and `imm_type` is 000.

## Timing
- Reset (asynchronous): state=FETCH, pending flag=0, `instret`=0, `illegal`=0. While `rst_n`=0, every strobe and `mem_req` is 0.
- Reset mid-access abandons the access. After release, the first `mem_req` comes no earlier than the first edge with `run`=1.
- Zero-wait latencies:
  - Load: 5 cycles.
  - Store, R-type, I-type: 4 cycles.
  - Branch: 3 cycles.
  - JAL: 4 cycles.
  - Each wait cycle adds 1.
- `mem_ready` is ignored whenever `mem_req`=0.
- `instret` updates on the clock edge ending the final cycle of the instruction.

## Structure
- Package `control_pkg` holds:
  - The state enum.
  - Opcode constants.
  - The `imm_type` encodings shared with the immediate/operand preparation logic.
  - The select encodings for `alu_src_a`, `alu_src_b`, `result_src` and `alu_op`.
- Sub-module `contador_instret` holds the CNT_W-bit retire counter with increment enable.

## Test plan
- Reset, then `run`=1 with zero-wait memory: sequence lw, sw, add, addi, beq (`zero`=1), jal → state trace 5/4/4/4/3/4 cycles, `instret`=6.
- Fetch with `mem_ready` delayed 3 cycles and `run` dropped after the first request → `mem_req` held 4 cycles, `ir_write`/`pc_write` exactly on the ready cycle.
- beq with `zero`=0 → `pc_write`=0 in BEQ, `instret` still incremented.
- Opcode 0001111 → TRAP, `illegal`=1, no further `mem_req` over 20 cycles; `rst_n` pulse clears it.
- `rst_n` asserted during a MEMREAD wait → all strobes 0 immediately, `instret`=0, FETCH resumes after release.
- Preload `instret` to all ones via 2^CNT_W−1 retires (CNT_W=4: 15 addi), one more → wraps to 0.
